opacc_tile_engine: RTL and testbench
====================================

Name: opacc_tile_engine

Overview:
- Parametrised, pipelined outer-product accumulator for the MPU.
- Holds NREGS accumulator tiles. Each tile is ML rows x VL columns of ACCW-bit elements.
- Each accepted op updates one tile: C[t] = C[t] + a*b^T, or C[t] = a*b^T, or C[t] = 0. Signed and unsigned operands are both supported.
- Tiles are loaded and stored row-serially over valid/ready streams, with an internal arbiter that removes the old caller-side exclusivity assertion.

Parameters:
- NREGS, 4, number of accumulator tiles (>=1).
- ML, 4, rows per tile (length of a).
- VL, 4, columns per tile (length of b).
- XLEN, 16, operand element width.
- ACCW, 64, accumulator element width. Must satisfy ACCW >= 2*XLEN; checked at elaboration.
- TW, max(1,$clog2(NREGS)), tile address width (derived).

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- op_valid, in, 1, compute op request.
- op_ready, out, 1, op accepted when op_valid & op_ready.
- op_mode, in, 2, operation select: 0 ACC, 1 SET (overwrite with a*b^T), 2 ZERO, 3 reserved (behaves as ZERO).
- op_signed, in, 1, 1 = operands are two's complement.
- op_tile, in, TW, target tile.
- ai, in, ML*XLEN, a vector; element i at [i*XLEN +: XLEN].
- bi, in, VL*XLEN, b vector; element j at [j*XLEN +: XLEN].
- ld_valid, in, 1, load row beat valid.
- ld_ready, out, 1, load beat accepted when ld_valid & ld_ready.
- ld_tile, in, TW, load target tile; sampled on the first beat only.
- ld_data, in, VL*ACCW, one row.
- st_req_valid, in, 1, store request.
- st_req_ready, out, 1, store request accepted.
- st_tile, in, TW, tile to store.
- st_valid, out, 1, store row beat valid.
- st_ready, in, 1, downstream ready.
- st_data, out, VL*ACCW, one row.
- st_last, out, 1, marks row ML-1.
- busy, out, 1, FSM not IDLE or pipeline non-empty.

Behaviour:
- Reset:
  - All tiles, pipeline valids, counters and the FSM clear.
  - Outputs after reset: op_ready=1, ld_ready=1, st_req_ready=1, st_valid=0, st_last=0, st_data=0, busy=0.
  - Reset mid-load, mid-store or with ops in flight aborts everything; no partial results survive.
- Compute pipeline, two stages:
  - S1 registers the ML*VL products. Each operand is sign- or zero-extended per op_signed; each product is 2*XLEN bits, then extended to ACCW.
  - S2 reads the target tile and writes the tile in the same cycle.
  - The tile is updated on the clock edge 2 cycles after acceptance. Throughput is 1 op/cycle.
  - Back-to-back ACC to the same tile is exact, because S2 does the read-modify-write.
- Arithmetic: the sum wraps modulo 2^ACCW; there is no saturation.
- FSM states: IDLE, LOAD, STORE.
  - op_ready = (state==IDLE) & ~ld_valid & ~st_req_valid. Load and store requests take priority over new ops.
  - IDLE->LOAD: on ld_valid when the pipeline is empty. This first beat is accepted that cycle. ld_ready=0 while the pipeline is non-empty.
  - IDLE->STORE: on st_req_valid when the pipeline is empty and ld_valid=0. Load wins over store when both are requested.
- LOAD:
  - A row counter r starts at 0; each accepted beat writes ld_data into row r of the latched tile.
  - After row ML-1 is written, return to IDLE.
  - ld_ready=1 throughout LOAD; st_req_ready=0.
- STORE:
  - st_req_ready=1 only in IDLE under the STORE-entry condition.
  - st_data is registered row r of the latched tile, and st_valid=1.
  - Data and st_last are held stable while st_ready=0.
  - r advances on st_valid & st_ready. The beat with r==ML-1 asserts st_last; its handshake returns the FSM to IDLE.
  - The first beat is valid in the cycle after request acceptance.
- Row counter wraps to 0 on leaving LOAD or STORE.
- Out-of-range tile address (NREGS not a power of two): the op, load or store still completes its handshakes but is dropped. Stores of such a tile output zeros.
- busy is deasserted one cycle after the last S2 write or the last load/store beat.

Test Plan:
- ACC, ML=VL=4, XLEN=16, unsigned, tile 0 from reset, a={1,2,3,4}, b={5,6,7,8}, issued twice back-to-back, then store tile 0 -> rows {10,12,14,16},{20,24,28,32},{30,36,42,48},{40,48,56,64}; st_last on beat 4 only.
- SET signed, a={-1,2,0,3}, b={4,-5,6,1}, then store -> row0 = {-4,5,-6,-1} sign-extended to 64 bits; row2 all zero.
- Load tile 2 with rows {1,1,1,1},{2,..},{3,..},{4,..}, then ACC a={1,1,1,1}, b={1,1,1,1}, then store -> rows {2},{3},{4},{5} in every column.
- Store with st_ready toggling 1,0,0,1,0,1,1 -> exactly 4 handshakes; data stable during stalls; op_ready=0 throughout STORE.
- ld_valid raised in the cycle after an ACC op is accepted -> ld_ready=0 until the ACC's S2 write completes; the loaded data then overwrites the ACC result.
- XLEN=16, ACCW=32, unsigned ACC a=b=0xFFFF applied 2 times -> element = 0xFFFC0002 (wraps); assert reset mid-STORE -> st_valid=0 the next cycle, store tile reads all zero.

Source files
------------

// File: rtl/opacc_tile_engine.sv
// Pipelined outer-product accumulator holding NREGS tiles of ML x VL ACCW-bit elements,
// with row-serial load/store streams that take priority over new compute ops.
module opacc_tile_engine #(
    parameter int unsigned NREGS = 4,
    parameter int unsigned ML    = 4,
    parameter int unsigned VL    = 4,
    parameter int unsigned XLEN  = 16,
    parameter int unsigned ACCW  = 64,
    localparam int unsigned TW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op_mode,
    input  logic               op_signed,
    input  logic [TW-1:0]      op_tile,
    input  logic [ML*XLEN-1:0] ai,
    input  logic [VL*XLEN-1:0] bi,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [TW-1:0]      ld_tile,
    input  logic [VL*ACCW-1:0] ld_data,
    input  logic               st_req_valid,
    output logic               st_req_ready,
    input  logic [TW-1:0]      st_tile,
    output logic               st_valid,
    input  logic               st_ready,
    output logic [VL*ACCW-1:0] st_data,
    output logic               st_last,
    output logic               busy
);

    localparam int unsigned RW = (ML > 1) ? $clog2(ML) : 1;

    if (ACCW < 2 * XLEN) begin : g_accw_chk
        $error("opacc_tile_engine: ACCW must be at least 2*XLEN");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE} state_t;

    state_t               state_q, state_d;
    logic [RW-1:0]        row_q, row_d;
    logic [TW-1:0]        lt_q, lt_d;
    logic                 st_valid_q, st_valid_d;
    logic                 st_last_q, st_last_d;
    logic [VL*ACCW-1:0]   st_data_q, st_data_d;

    logic [ACCW-1:0]      tiles_q [NREGS][ML][VL];

    logic                 s1_valid_q;
    logic [1:0]           s1_mode_q;
    logic [TW-1:0]        s1_tile_q;
    logic [ACCW-1:0]      s1_prod_q [ML][VL];

    logic                 op_fire_c;
    logic                 ld_we_c;
    logic [TW-1:0]        ld_wtile_c;
    logic                 last_row_c;

    function automatic logic tile_ok(input logic [TW-1:0] t);
        return 32'(t) < NREGS;
    endfunction

    // Product of two extended operands, truncated to 2*XLEN, then extended to ACCW.
    function automatic logic [ACCW-1:0] mul_ext(input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b,
                                                input logic sgn);
        logic signed [XLEN:0]     ax;
        logic signed [XLEN:0]     bx;
        logic signed [2*XLEN+1:0] p;
        logic [2*XLEN-1:0]        pl;
        ax = $signed({sgn & a[XLEN-1], a});
        bx = $signed({sgn & b[XLEN-1], b});
        p  = (2*XLEN+2)'(ax) * (2*XLEN+2)'(bx);
        pl = p[2*XLEN-1:0];
        if (sgn) return ACCW'($signed(pl));
        return ACCW'(pl);
    endfunction

    function automatic logic [VL*ACCW-1:0] read_row(input logic [TW-1:0] t,
                                                    input logic [RW-1:0] r);
        logic [VL*ACCW-1:0] row;
        row = '0;
        if (tile_ok(t)) begin
            for (int j = 0; j < VL; j++) row[j*ACCW +: ACCW] = tiles_q[t][r][j];
        end
        return row;
    endfunction

    assign last_row_c = (row_q == RW'(ML - 1));
    assign st_valid   = st_valid_q;
    assign st_last    = st_last_q;
    assign st_data    = st_data_q;
    assign busy       = (state_q != S_IDLE) | s1_valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            lt_q       <= '0;
            st_valid_q <= 1'b0;
            st_last_q  <= 1'b0;
            st_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            lt_q       <= lt_d;
            st_valid_q <= st_valid_d;
            st_last_q  <= st_last_d;
            st_data_q  <= st_data_d;
        end
    end

    // Next-state, handshakes and store beat generation.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        lt_d         = lt_q;
        st_valid_d   = st_valid_q;
        st_last_d    = st_last_q;
        st_data_d    = st_data_q;
        op_ready     = 1'b0;
        ld_ready     = 1'b0;
        st_req_ready = 1'b0;
        ld_we_c      = 1'b0;
        ld_wtile_c   = lt_q;
        unique case (state_q)
            S_IDLE: begin
                op_ready     = ~ld_valid & ~st_req_valid;
                ld_ready     = ~s1_valid_q;
                st_req_ready = ~s1_valid_q & ~ld_valid;
                if (ld_valid && !s1_valid_q) begin
                    ld_we_c    = 1'b1;
                    ld_wtile_c = ld_tile;
                    lt_d       = ld_tile;
                    if (ML > 1) begin
                        state_d = S_LOAD;
                        row_d   = RW'(1);
                    end
                end else if (st_req_valid && !s1_valid_q) begin
                    state_d    = S_STORE;
                    lt_d       = st_tile;
                    row_d      = '0;
                    st_valid_d = 1'b1;
                    st_last_d  = (ML == 1);
                    st_data_d  = read_row(st_tile, '0);
                end
            end
            S_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ld_we_c = 1'b1;
                    if (last_row_c) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            S_STORE: begin
                if (st_ready) begin
                    if (last_row_c) begin
                        state_d    = S_IDLE;
                        row_d      = '0;
                        st_valid_d = 1'b0;
                        st_last_d  = 1'b0;
                        st_data_d  = '0;
                    end else begin
                        row_d     = row_q + RW'(1);
                        st_last_d = (row_q + RW'(1)) == RW'(ML - 1);
                        st_data_d = read_row(lt_q, row_q + RW'(1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign op_fire_c = op_valid & op_ready;

    // S1: register extended products of the accepted op.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_tile_q  <= '0;
            for (int i = 0; i < ML; i++)
                for (int j = 0; j < VL; j++) s1_prod_q[i][j] <= '0;
        end else begin
            s1_valid_q <= op_fire_c;
            if (op_fire_c) begin
                s1_mode_q <= op_mode;
                s1_tile_q <= op_tile;
                for (int i = 0; i < ML; i++)
                    for (int j = 0; j < VL; j++)
                        s1_prod_q[i][j] <= mul_ext(ai[i*XLEN +: XLEN], bi[j*XLEN +: XLEN], op_signed);
            end
        end
    end

    // S2 read-modify-write and load row writes; the arbiter keeps them mutually exclusive.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < NREGS; t++)
                for (int i = 0; i < ML; i++)
                    for (int j = 0; j < VL; j++) tiles_q[t][i][j] <= '0;
        end else begin
            if (s1_valid_q && tile_ok(s1_tile_q)) begin
                for (int i = 0; i < ML; i++) begin
                    for (int j = 0; j < VL; j++) begin
                        unique case (s1_mode_q)
                            2'd0:    tiles_q[s1_tile_q][i][j] <= tiles_q[s1_tile_q][i][j] + s1_prod_q[i][j];
                            2'd1:    tiles_q[s1_tile_q][i][j] <= s1_prod_q[i][j];
                            default: tiles_q[s1_tile_q][i][j] <= '0;
                        endcase
                    end
                end
            end
            if (ld_we_c && tile_ok(ld_wtile_c)) begin
                for (int j = 0; j < VL; j++) tiles_q[ld_wtile_c][row_q][j] <= ld_data[j*ACCW +: ACCW];
            end
        end
    end

endmodule

// File: tb/tb_opacc_tile_engine.sv
// Scoreboard bench for opacc_tile_engine: a 64-bit, 4-tile instance for the main flows and
// a 32-bit, 3-tile instance for wraparound and out-of-range tile handling.
module tb_opacc_tile_engine;

    localparam int ML = 4;
    localparam int VL = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic         op_valid, op_ready, op_signed, ld_valid, ld_ready;
    logic         st_req_valid, st_req_ready, st_valid, st_ready, st_last, busy;
    logic [1:0]   op_mode, op_tile, ld_tile, st_tile;
    logic [63:0]  ai, bi;
    logic [255:0] ld_data, st_data;

    logic         d2_op_valid, d2_op_ready, d2_op_signed, d2_ld_valid, d2_ld_ready;
    logic         d2_st_req_valid, d2_st_req_ready, d2_st_valid, d2_st_ready, d2_st_last, d2_busy;
    logic [1:0]   d2_op_mode, d2_op_tile, d2_ld_tile, d2_st_tile;
    logic [63:0]  d2_ai, d2_bi;
    logic [127:0] d2_ld_data, d2_st_data;

    logic [63:0]  mdl [4][4][4];
    logic [255:0] exp_q [$];
    logic [127:0] exp2_q [$];

    always #5 clk = ~clk;

    opacc_tile_engine #(.NREGS(4), .ML(ML), .VL(VL), .XLEN(16), .ACCW(64)) u_dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_mode(op_mode), .op_signed(op_signed),
        .op_tile(op_tile), .ai(ai), .bi(bi),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_tile(ld_tile), .ld_data(ld_data),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_tile(st_tile),
        .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data), .st_last(st_last),
        .busy(busy)
    );

    opacc_tile_engine #(.NREGS(3), .ML(ML), .VL(VL), .XLEN(16), .ACCW(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .op_valid(d2_op_valid), .op_ready(d2_op_ready), .op_mode(d2_op_mode),
        .op_signed(d2_op_signed), .op_tile(d2_op_tile), .ai(d2_ai), .bi(d2_bi),
        .ld_valid(d2_ld_valid), .ld_ready(d2_ld_ready), .ld_tile(d2_ld_tile), .ld_data(d2_ld_data),
        .st_req_valid(d2_st_req_valid), .st_req_ready(d2_st_req_ready), .st_tile(d2_st_tile),
        .st_valid(d2_st_valid), .st_ready(d2_st_ready), .st_data(d2_st_data),
        .st_last(d2_st_last), .busy(d2_busy)
    );

    function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                          input logic [15:0] e2, input logic [15:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic clear_model();
        for (int t = 0; t < 4; t++)
            for (int i = 0; i < ML; i++)
                for (int j = 0; j < VL; j++) mdl[t][i][j] = '0;
    endtask

    task automatic issue_op(input logic [1:0] mode, input logic sgn, input logic [1:0] tile,
                            input logic [63:0] a, input logic [63:0] b);
        logic rdy, done;
        logic signed [63:0] ax, bx, p;
        done = 1'b0;
        op_valid = 1'b1; op_mode = mode; op_signed = sgn; op_tile = tile; ai = a; bi = b;
        for (int k = 0; k < 50 && !done; k++) begin
            #1 rdy = op_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
        end
        op_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL op_accept tile=%0d: no handshake within 50 cycles", tile);
        end else begin
            for (int i = 0; i < ML; i++) begin
                for (int j = 0; j < VL; j++) begin
                    ax = sgn ? 64'($signed(a[i*16 +: 16])) : 64'(a[i*16 +: 16]);
                    bx = sgn ? 64'($signed(b[j*16 +: 16])) : 64'(b[j*16 +: 16]);
                    p  = ax * bx;
                    case (mode)
                        2'd0:    mdl[tile][i][j] = mdl[tile][i][j] + p;
                        2'd1:    mdl[tile][i][j] = p;
                        default: mdl[tile][i][j] = '0;
                    endcase
                end
            end
        end
    endtask

    // Row r, column j carries base + r + cstep*j; ld_tile is scrambled after the first beat.
    task automatic load_tile(input logic [1:0] tile, input logic [63:0] base,
                             input logic [63:0] cstep, output int stalls);
        logic rdy;
        int beats;
        stalls = 0; beats = 0;
        ld_valid = 1'b1; ld_tile = tile;
        for (int k = 0; k < 50 && beats < ML; k++) begin
            for (int j = 0; j < VL; j++) ld_data[j*64 +: 64] = base + 64'(beats) + cstep * 64'(j);
            #1 rdy = ld_ready;
            @(posedge clk); #1;
            if (rdy) begin
                for (int j = 0; j < VL; j++) mdl[tile][beats][j] = ld_data[j*64 +: 64];
                beats++;
                ld_tile = tile ^ 2'b01;
            end else if (beats == 0) begin
                stalls++;
            end
        end
        ld_valid = 1'b0;
        total++;
        if (beats != ML) begin
            bad++;
            $display("FAIL load_beats tile=%0d got=%0d exp=%0d", tile, beats, ML);
        end
    endtask

    task automatic req_store(input logic [1:0] tile, output logic ok);
        logic rdy;
        ok = 1'b0;
        st_req_valid = 1'b1; st_tile = tile; st_ready = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1 rdy = st_req_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        st_req_valid = 1'b0;
        st_tile = ~tile;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL st_req_accept tile=%0d: no handshake within 50 cycles", tile);
        end
    endtask

    // Pushes the model's rows, then pops one per handshake while st_ready follows pat (LSB first).
    task automatic store_check(input logic [1:0] tile, input logic [15:0] pat, input string name);
        logic [255:0] row, held, expr;
        logic held_last, stalled, ok;
        logic [15:0] p;
        int beats;
        for (int r = 0; r < ML; r++) begin
            for (int j = 0; j < VL; j++) row[j*64 +: 64] = mdl[tile][r][j];
            exp_q.push_back(row);
        end
        req_store(tile, ok);
        beats = 0; stalled = 1'b0; held = '0; held_last = 1'b0; p = pat;
        for (int cyc = 0; cyc < 64 && beats < ML && ok; cyc++) begin
            st_ready = p[0];
            p = {1'b1, p[15:1]};
            #1;
            total++;
            if (op_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s op_ready_in_store cyc=%0d got=%b exp=0", name, cyc, op_ready);
            end
            total++;
            if (st_valid !== 1'b1) begin
                bad++;
                $display("FAIL %s st_valid cyc=%0d got=%b exp=1", name, cyc, st_valid);
            end
            if (stalled) begin
                total++;
                if (st_data !== held || st_last !== held_last) begin
                    bad++;
                    $display("FAIL %s stall_hold cyc=%0d got=%h/%b exp=%h/%b", name, cyc,
                             st_data, st_last, held, held_last);
                end
            end
            if (st_valid && st_ready) begin
                expr = exp_q.pop_front();
                total++;
                if (st_data !== expr) begin
                    bad++;
                    $display("FAIL %s row%0d got=%h exp=%h", name, beats, st_data, expr);
                end
                total++;
                if (st_last !== (beats == ML - 1)) begin
                    bad++;
                    $display("FAIL %s st_last beat=%0d got=%b exp=%b", name, beats, st_last,
                             beats == ML - 1);
                end
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; held = st_data; held_last = st_last;
            end
            @(posedge clk); #1;
        end
        st_ready = 1'b0;
        total++;
        if (beats != ML) begin
            bad++;
            $display("FAIL %s beats got=%0d exp=%0d", name, beats, ML);
        end
        exp_q.delete();
        #1;
        total++;
        if (st_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s st_valid_after got=%b exp=0", name, st_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic d2_op(input logic [1:0] tile, input logic [63:0] a, input logic [63:0] b);
        logic rdy, done;
        done = 1'b0;
        d2_op_valid = 1'b1; d2_op_mode = 2'd0; d2_op_signed = 1'b0; d2_op_tile = tile;
        d2_ai = a; d2_bi = b;
        for (int k = 0; k < 50 && !done; k++) begin
            #1 rdy = d2_op_ready;
            @(posedge clk); #1;
            if (rdy) done = 1'b1;
        end
        d2_op_valid = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL d2_op_accept tile=%0d: no handshake within 50 cycles", tile);
        end
    endtask

    task automatic d2_store(input logic [1:0] tile, input string name);
        logic rdy, ok;
        logic [127:0] expr;
        int beats;
        ok = 1'b0; beats = 0;
        d2_st_req_valid = 1'b1; d2_st_tile = tile; d2_st_ready = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1 rdy = d2_st_req_ready;
            @(posedge clk); #1;
            if (rdy) ok = 1'b1;
        end
        d2_st_req_valid = 1'b0;
        for (int k = 0; k < 20 && beats < ML && ok; k++) begin
            #1;
            if (d2_st_valid) begin
                expr = exp2_q.pop_front();
                total++;
                if (d2_st_data !== expr) begin
                    bad++;
                    $display("FAIL %s row%0d got=%h exp=%h", name, beats, d2_st_data, expr);
                end
                total++;
                if (d2_st_last !== (beats == ML - 1)) begin
                    bad++;
                    $display("FAIL %s st_last beat=%0d got=%b", name, beats, d2_st_last);
                end
                beats++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (beats != ML) begin
            bad++;
            $display("FAIL %s beats got=%0d exp=%0d", name, beats, ML);
        end
        exp2_q.delete();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({op_ready, ld_ready, st_req_ready} !== 3'b111) begin
            bad++;
            $display("FAIL reset_readies got=%b exp=111", {op_ready, ld_ready, st_req_ready});
        end
        total++;
        if ({st_valid, st_last, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_valid_last_busy got=%b exp=000", {st_valid, st_last, busy});
        end
        total++;
        if (st_data !== '0) begin
            bad++;
            $display("FAIL reset_st_data got=%h exp=0", st_data);
        end
        total++;
        if ({d2_op_ready, d2_st_valid, d2_busy} !== 3'b100) begin
            bad++;
            $display("FAIL reset_dut32 got=%b exp=100", {d2_op_ready, d2_st_valid, d2_busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_acc_b2b();
        issue_op(2'd0, 1'b0, 2'd0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        issue_op(2'd0, 1'b0, 2'd0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL acc_busy got=%b exp=1", busy);
        end
        total++;
        if (mdl[0][1][3] !== 64'd32) begin
            bad++;
            $display("FAIL acc_model_row1 got=%0d exp=32", mdl[0][1][3]);
        end
        store_check(2'd0, 16'hFFFF, "acc_b2b");
    endtask

    task automatic test_set_signed();
        issue_op(2'd1, 1'b1, 2'd1, pack4(16'hFFFF, 2, 0, 3), pack4(4, 16'hFFFB, 6, 1));
        store_check(2'd1, 16'hFFFF, "set_signed");
    endtask

    task automatic test_load_acc();
        int stalls;
        load_tile(2'd2, 64'd1, 64'd0, stalls);
        issue_op(2'd0, 1'b0, 2'd2, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        store_check(2'd2, 16'hFFFF, "load_acc");
    endtask

    task automatic test_store_stall();
        store_check(2'd1, 16'hFFE9, "store_stall");
    endtask

    task automatic test_ld_after_acc();
        int stalls;
        issue_op(2'd0, 1'b0, 2'd3, pack4(1, 1, 1, 1), pack4(1, 1, 1, 1));
        load_tile(2'd3, 64'h70, 64'h1000, stalls);
        total++;
        if (stalls != 1) begin
            bad++;
            $display("FAIL ld_after_acc_stalls got=%0d exp=1", stalls);
        end
        store_check(2'd3, 16'hFFFF, "ld_after_acc");
    endtask

    task automatic test_zero_modes();
        issue_op(2'd2, 1'b0, 2'd0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
        issue_op(2'd3, 1'b1, 2'd1, pack4(5, 5, 5, 5), pack4(5, 5, 5, 5));
        store_check(2'd0, 16'hFFFF, "mode_zero");
        store_check(2'd1, 16'hFFFF, "mode_reserved");
    endtask

    task automatic test_wrap_oor();
        logic [63:0] ff;
        ff = pack4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        d2_op(2'd0, ff, ff);
        d2_op(2'd0, ff, ff);
        for (int r = 0; r < ML; r++) exp2_q.push_back({4{32'hFFFC0002}});
        d2_store(2'd0, "wrap32");
        d2_op(2'd3, ff, ff);
        for (int r = 0; r < ML; r++) exp2_q.push_back('0);
        d2_store(2'd3, "out_of_range");
    endtask

    task automatic test_reset_mid_store();
        logic ok;
        req_store(2'd2, ok);
        #1;
        total++;
        if (st_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_store_valid got=%b exp=1", st_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        total++;
        if (st_valid !== 1'b0 || st_data !== '0) begin
            bad++;
            $display("FAIL reset_mid_store got=%b/%h exp=0/0", st_valid, st_data);
        end
        total++;
        if (op_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_store_ctrl got=%b%b exp=10", op_ready, busy);
        end
        clear_model();
        store_check(2'd2, 16'hFFFF, "after_reset");
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 0; op_mode = 0; op_signed = 0; op_tile = 0; ai = 0; bi = 0;
        ld_valid = 0; ld_tile = 0; ld_data = 0; st_req_valid = 0; st_tile = 0; st_ready = 0;
        d2_op_valid = 0; d2_op_mode = 0; d2_op_signed = 0; d2_op_tile = 0; d2_ai = 0; d2_bi = 0;
        d2_ld_valid = 0; d2_ld_tile = 0; d2_ld_data = 0;
        d2_st_req_valid = 0; d2_st_tile = 0; d2_st_ready = 0;
        clear_model();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_acc_b2b();
        test_set_signed();
        test_load_acc();
        test_store_stall();
        test_ld_after_acc();
        test_zero_modes();
        test_wrap_oor();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
